// File: rtl/packet_sfifo_drop.sv
// packet_sfifo_drop: store-and-forward packet FIFO that discards dropped or oversized packets.
// Define PACKET_SFIFO_STAT_EN to add the saturating drop_cnt/commit_cnt statistics outputs.
module packet_sfifo_drop #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 64,
  parameter int AFULL_THRESH = FIFO_DEPTH - 8,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdrop,
  output logic                  afull,
  output logic                  full,
  output logic [CW-1:0]         wrcnt,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic [CW-1:0]         rdcnt,
  output logic [CW-1:0]         pkt_cnt,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  drop
`ifdef PACKET_SFIFO_STAT_EN
  ,
  output logic [31:0]           drop_cnt,
  output logic [31:0]           commit_cnt
`endif
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PKT     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_wptr, r_cptr, r_rptr, r_pkt_cnt;
  logic [1:0]            r_state, w_state_nxt;
  logic                  r_overflow, r_underflow, r_drop;
  logic                  w_eop, w_open, w_acc, w_commit, w_discard, w_ovf, w_rd, w_rd_eop;

  assign wrcnt   = r_wptr - r_rptr;
  assign rdcnt   = r_cptr - r_rptr;
  assign full    = wrcnt == CW'(FIFO_DEPTH);
  assign afull   = wrcnt >= CW'(AFULL_THRESH);
  assign pkt_cnt = r_pkt_cnt;
  assign empty   = r_pkt_cnt == '0;
  assign rdata   = r_mem[r_rptr[CW-2:0]];

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign drop      = r_drop;

  assign w_eop     = wdata[DATA_WIDTH-1];
  assign w_open    = r_state != S_DISCARD;
  assign w_acc     = wen & ~full & w_open;
  assign w_commit  = w_acc & w_eop & ~wdrop;
  assign w_discard = w_acc & w_eop & wdrop;
  assign w_ovf     = wen & full & w_open;
  assign w_rd      = ren & ~empty;
  assign w_rd_eop  = w_rd & rdata[DATA_WIDTH-1];

  // An overflowing word that itself ends the packet needs no discard phase.
  assign w_state_nxt = w_ovf ? (w_eop ? S_IDLE : S_DISCARD) :
                       w_acc ? (w_eop ? S_IDLE : S_PKT) :
                       (!w_open && wen && w_eop) ? S_IDLE : r_state;

  always_ff @(posedge clk)
    if (w_acc) r_mem[r_wptr[CW-2:0]] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr      <= '0;
      r_cptr      <= '0;
      r_rptr      <= '0;
      r_pkt_cnt   <= '0;
      r_state     <= S_IDLE;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_wptr      <= (w_ovf || w_discard) ? r_cptr : w_acc ? r_wptr + 1'b1 : r_wptr;
      r_cptr      <= w_commit ? r_wptr + 1'b1 : r_cptr;
      r_rptr      <= w_rd ? r_rptr + 1'b1 : r_rptr;
      r_pkt_cnt   <= r_pkt_cnt + CW'(w_commit) - CW'(w_rd_eop);
      r_state     <= w_state_nxt;
      r_overflow  <= w_ovf;
      r_underflow <= ren & empty;
      r_drop      <= w_ovf | w_discard;
    end

`ifdef PACKET_SFIFO_STAT_EN
  logic [31:0] r_drop_cnt, r_commit_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign commit_cnt = r_commit_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_drop_cnt   <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_drop_cnt   <= ((w_ovf || w_discard) && r_drop_cnt != '1) ? r_drop_cnt + 1'b1 : r_drop_cnt;
      r_commit_cnt <= (w_commit && r_commit_cnt != '1) ? r_commit_cnt + 1'b1 : r_commit_cnt;
    end
`endif
endmodule

// File: tb/tb_packet_sfifo_drop.sv
// tb_packet_sfifo_drop: directed vector table plus hand-written multi-cycle sequences for packet_sfifo_drop.
module tb_packet_sfifo_drop;
  localparam int CW = 7;
  localparam logic [31:0] E = 32'h8000_0000;

  logic clk = 1'b0, rst = 1'b1;
  logic wen = 1'b0, wdrop = 1'b0, ren = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic afull, full, empty, overflow, underflow, drop;
  logic [CW-1:0] wrcnt, rdcnt, pkt_cnt;
`ifdef PACKET_SFIFO_STAT_EN
  logic [31:0] drop_cnt, commit_cnt;
`endif
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  packet_sfifo_drop dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .wdrop(wdrop),
    .afull(afull), .full(full), .wrcnt(wrcnt), .ren(ren), .rdata(rdata),
    .empty(empty), .rdcnt(rdcnt), .pkt_cnt(pkt_cnt),
    .overflow(overflow), .underflow(underflow), .drop(drop)
`ifdef PACKET_SFIFO_STAT_EN
    , .drop_cnt(drop_cnt), .commit_cnt(commit_cnt)
`endif
  );

  typedef struct {
    logic wen; logic [31:0] wdata; logic wdrop; logic ren;
    logic e_empty; int e_pkt; int e_rdcnt; int e_wrcnt;
    logic e_drop; logic e_ovf; logic e_unf;
    logic chk_rd; logic [31:0] e_rdata;
  } vec_t;
  vec_t v[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic dr, input logic r);
    @(negedge clk);
    wen = w; wdata = d; wdrop = dr; ren = r;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; wdrop = 1'b0;
  endtask

  initial begin
    v[0]  = '{1, 32'h11,   0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0};
    v[1]  = '{1, 32'h12,   0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 32'h0};
    v[2]  = '{1, 32'h13,   0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 32'h0};
    v[3]  = '{1, E|32'h14, 0, 0, 0, 1, 4, 4, 0, 0, 0, 1, 32'h11};
    v[4]  = '{0, 32'h0,    0, 1, 0, 1, 3, 3, 0, 0, 0, 1, 32'h12};
    v[5]  = '{0, 32'h0,    0, 1, 0, 1, 2, 2, 0, 0, 0, 1, 32'h13};
    v[6]  = '{0, 32'h0,    0, 1, 0, 1, 1, 1, 0, 0, 0, 1, E|32'h14};
    v[7]  = '{0, 32'h0,    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0};
    v[8]  = '{1, 32'h21,   0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0};
    v[9]  = '{1, 32'h22,   0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 32'h0};
    v[10] = '{1, 32'h23,   0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 32'h0};
    v[11] = '{1, 32'h24,   0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 32'h0};
    v[12] = '{1, E|32'h25, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0};
    v[13] = '{0, 32'h0,    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0};
    v[14] = '{0, 32'h0,    0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0};
    v[15] = '{0, 32'h0,    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_wrcnt", 32'(wrcnt), 0);
    chk("rst_rdcnt", 32'(rdcnt), 0);
    chk("rst_pkt", 32'(pkt_cnt), 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(v[i].wen, v[i].wdata, v[i].wdrop, v[i].ren);
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(v[i].e_empty));
      chk($sformatf("v%0d_pkt", i), 32'(pkt_cnt), 32'(v[i].e_pkt));
      chk($sformatf("v%0d_rdcnt", i), 32'(rdcnt), 32'(v[i].e_rdcnt));
      chk($sformatf("v%0d_wrcnt", i), 32'(wrcnt), 32'(v[i].e_wrcnt));
      chk($sformatf("v%0d_drop", i), 32'(drop), 32'(v[i].e_drop));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(v[i].e_ovf));
      chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(v[i].e_unf));
      if (v[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdata, v[i].e_rdata);
    end

    for (int i = 1; i <= 70; i++) begin
      step(1'b1, (i == 70 ? E : 32'h0) | 32'(i), 1'b0, 1'b0);
      if (i == 55) chk("long_afull55", 32'(afull), 0);
      if (i == 56) chk("long_afull56", 32'(afull), 1);
      if (i == 64) begin
        chk("long_full64", 32'(full), 1);
        chk("long_wrcnt64", 32'(wrcnt), 64);
      end
      if (i == 65) begin
        chk("long_ovf65", 32'(overflow), 1);
        chk("long_drop65", 32'(drop), 1);
        chk("long_full65", 32'(full), 0);
      end
      if (i >= 65) chk($sformatf("long_wrcnt%0d", i), 32'(wrcnt), 0);
      if (i >= 66) chk($sformatf("long_ovf%0d", i), 32'(overflow), 0);
    end
    chk("long_pkt", 32'(pkt_cnt), 0);
    chk("long_empty", 32'(empty), 1);

    step(1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, E | 32'h32, 1'b0, 1'b0);
    chk("two_pkt", 32'(pkt_cnt), 1);
    chk("two_rdcnt", 32'(rdcnt), 2);
    chk("two_rdata", rdata, 32'h31);

    step(1'b1, 32'h41, 1'b0, 1'b1);
    chk("sim1_rdata", rdata, E | 32'h32);
    chk("sim1_wrcnt", 32'(wrcnt), 2);
    step(1'b1, E | 32'h42, 1'b0, 1'b1);
    chk("sim_pkt", 32'(pkt_cnt), 1);
    chk("sim_rdata", rdata, 32'h41);
    chk("sim_rdcnt", 32'(rdcnt), 2);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_rdata", rdata, E | 32'h42);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_pkt", 32'(pkt_cnt), 0);

    step(1'b1, E | 32'h51, 1'b0, 1'b0);
    step(1'b1, 32'h52, 1'b0, 1'b0);
    step(1'b1, 32'h53, 1'b0, 1'b0);
    chk("pre_rst_wrcnt", 32'(wrcnt), 3);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_pkt", 32'(pkt_cnt), 0);
    chk("mid_rst_wrcnt", 32'(wrcnt), 0);
    chk("mid_rst_rdcnt", 32'(rdcnt), 0);
    @(negedge clk) rst = 1'b0;
    step(1'b1, E | 32'h61, 1'b0, 1'b0);
    chk("post_rst_pkt", 32'(pkt_cnt), 1);
    chk("post_rst_rdcnt", 32'(rdcnt), 1);
    chk("post_rst_rdata", rdata, E | 32'h61);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_empty", 32'(empty), 1);

`ifdef PACKET_SFIFO_STAT_EN
    step(1'b1, E | 32'h71, 1'b0, 1'b0);
    step(1'b1, E | 32'h72, 1'b0, 1'b0);
    step(1'b1, E | 32'h73, 1'b1, 1'b0);
    step(1'b1, E | 32'h74, 1'b1, 1'b0);
    chk("stat_commit", commit_cnt, 3);
    chk("stat_drop", drop_cnt, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/packet_sfifo_drop.md
PACKET_SFIFO_DROP -- requirements
Module: packet_sfifo_drop

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width; bit DATA_WIDTH-1 is the packet eop flag.
REQ-002 SHALL have parameter FIFO_DEPTH, default 64: words; power of two, minimum 8.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-8: afull asserts when wrcnt >= this value.
REQ-004 SHALL have localparam CW = log2(FIFO_DEPTH)+1, the width of every count output.
REQ-005 SHALL have ports clk (in, 1): single clock, and rst (in, 1): asynchronous reset, active high.
REQ-006 SHALL have write ports: wen in 1; wdata in DATA_WIDTH; wdrop in 1 (sampled with eop, discards the packet); afull out 1; full out 1; wrcnt out CW (stored words, committed and uncommitted).
REQ-007 SHALL have read ports: ren in 1; rdata out DATA_WIDTH (first-word fall-through); empty out 1; rdcnt out CW (committed unread words); pkt_cnt out CW (committed packets not fully read).
REQ-008 SHALL have status ports: overflow out 1; underflow out 1; drop out 1 (one-cycle pulse per discarded packet).

Function
REQ-009 SHALL keep three pointers, each CW bits wide and wrapping modulo 2*FIFO_DEPTH: wptr (write), cptr (last commit), rptr (read).
REQ-010 SHALL compute wrcnt = wptr-rptr, rdcnt = cptr-rptr, full = (wrcnt == FIFO_DEPTH), all combinationally.
REQ-011 SHALL run a write FSM with states IDLE, PKT (mid-packet) and DISCARD.
REQ-012 SHALL accept a word when wen=1, full=0 and state is not DISCARD; it is stored at wptr and wptr increments.
REQ-013 SHALL commit when an accepted word has eop=1 and wdrop=0: on the next edge cptr <= wptr+1, pkt_cnt increments, and the FSM enters IDLE.
REQ-014 SHALL discard when an accepted word has eop=1 and wdrop=1: wptr rolls back to cptr, drop pulses, and the FSM enters IDLE.
REQ-015 SHALL handle wen=1 with full=1 as follows: overflow pulses for one cycle, wptr rolls back to cptr, drop pulses, and the FSM enters DISCARD; if that word carries eop, the FSM enters IDLE instead.
REQ-016 SHALL, in DISCARD, ignore all words (no write, no overflow) until a word with eop arrives, then return to IDLE.
REQ-017 SHALL drive empty = (pkt_cnt == 0): store-and-forward; no word is readable before its eop is committed.
REQ-018 SHALL drive rdata = mem[rptr] combinationally, valid whenever empty=0.
REQ-019 SHALL increment rptr when ren=1 and empty=0; if that word carries eop, pkt_cnt decrements.
REQ-020 SHALL, when ren=1 and empty=1, pulse underflow and change no state.
REQ-021 SHALL leave pkt_cnt unchanged on a simultaneous commit and eop read in the same cycle.
REQ-022 SHALL allow a rollback and a read in the same cycle: wptr <= cptr while rptr advances independently.
REQ-023 SHALL always discard a packet longer than FIFO_DEPTH, via REQ-015.

Reset
REQ-024 SHALL, while rst=1, clear asynchronously: wptr, cptr, rptr, pkt_cnt and all counters to 0; FSM to IDLE; overflow, underflow and drop to 0.
REQ-025 SHALL therefore present outputs during reset as: empty=1, full=0, afull=0, wrcnt=0, rdcnt=0, pkt_cnt=0.
REQ-026 SHALL not reset memory contents; rdata is don't-care while empty=1.
REQ-027 SHALL lose any packet in flight when reset is asserted mid-packet; after release the FSM starts in IDLE and treats the next word as a packet start.

Configuration
REQ-028 SHALL, with macro PACKET_SFIFO_STAT_EN defined, add outputs drop_cnt [31:0] and commit_cnt [31:0], each saturating at 32'hFFFFFFFF, incremented on drop and commit pulses respectively, and cleared by rst.
REQ-029 SHALL, without PACKET_SFIFO_STAT_EN, omit these ports and their logic entirely.

Verification
REQ-030 SHALL cover: a 4-word packet (eop on word 4), DEPTH=64 -> empty=1 through the write, empty=0 the cycle after eop, pkt_cnt=1, rdcnt=4; four reads return words in order, then empty=1 and pkt_cnt=0.
REQ-031 SHALL cover: a 5-word packet with wdrop=1 on eop -> drop pulses once, wrcnt returns to 0, pkt_cnt=0, empty stays 1.
REQ-032 SHALL cover: a 70-word packet, DEPTH=64 -> overflow pulses on word 65, wrcnt=0 the next cycle, words 66-70 ignored, pkt_cnt=0; a following 2-word packet commits normally.
REQ-033 SHALL cover: with pkt_cnt=1, committing a second packet in the same cycle as the eop read of the first -> pkt_cnt stays 1, rdata = word 0 of packet 2.
REQ-034 SHALL cover: ren=1 while empty=1 -> underflow pulses one cycle, rptr unchanged; rst asserted mid-packet -> all counts 0 and empty=1 immediately.
REQ-035 SHALL cover, with PACKET_SFIFO_STAT_EN defined: 3 commits and 2 drops -> commit_cnt=3, drop_cnt=2.
